lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Load/store unit of the MEM stage in the pipelined RV32I core.
- Sits directly upstream of the MEM/WB pipeline register.
- Decodes the EX/MEM address into data memory or memory-mapped I/O, performs byte/half/word stores, and returns formatted load data one cycle later, aligned with the WB stage.
- Owns the LEDR/LEDG/HEX/LCD output registers that the MEM/WB register forwards to the board.

Parameters:
DMEM_AW, 16, byte-address width of data memory (2**DMEM_AW bytes, word-organised)
DMEM_INIT, "", optional hex init file for data memory; empty means no init

Ports:
i_clk  in  1  clock
i_reset  in  1  reset
i_lsu_addr  in  32  byte address from ALU result
i_st_data  in  32  store data (rs2)
i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_lsu_wren  in  1  store request
i_lsu_rden  in  1  load request
i_io_sw  in  32  board switches
i_io_btn  in  4  board buttons, active-high
o_ld_data  out  32  formatted load data, valid the cycle after request
o_misaligned  out  1  registered misalignment flag for the previous request
o_io_ledr  out  32  red LED register
o_io_ledg  out  32  green LED register
o_io_lcd  out  32  LCD register
o_io_hex0..o_io_hex7  out  7 each  seven-segment registers

Behaviour:
- Reset: i_reset, asynchronous, active-low; clock i_clk. On reset, every output is 0 and all I/O registers are cleared. DMEM contents are not reset.
- Address map (decode on i_lsu_addr[31:12]):
  - addr[31:DMEM_AW]==0: DMEM.
  - 0x10000: LEDR.
  - 0x10001: LEDG.
  - 0x10002: HEX0-3. Byte n [6:0] maps to hexn; bit 7 of each byte is read as 0.
  - 0x10003: HEX4-7, same byte layout.
  - 0x10004: LCD.
  - 0x10010: SW, read-only.
  - 0x10011: BTN, read-only, zero-extended.
  - All other addresses: unmapped.
- Byte enables come from funct3 and addr[1:0].
  - Store data is replicated into the addressed lane(s): SB to all 4 lanes, SH to both halves.
  - Only enabled lanes are written.
- Store:
  - Write takes effect at the clock edge where i_lsu_wren=1.
  - An I/O output register changes on that same edge, so o_io_* shows the new value in the following cycle.
  - Stores to read-only or unmapped addresses are ignored.
- Load:
  - Registered read with latency 1.
  - The request cycle latches the word, the byte offset, funct3 and the region select. o_ld_data is valid the next cycle.
  - Formatting is applied on the registered word:
    - B sign-extends; BU zero-extends the selected byte.
    - H sign-extends; HU zero-extends the selected half.
    - W passes the word through.
  - Output registers read back their current value.
  - Unmapped reads return 0.
- Store followed by a load to the same address in the next cycle must return the new data.
- o_ld_data is 0 in each of these cases:
  - the cycle after no load;
  - the cycle after a store;
  - the cycle after a load with an illegal funct3 (011, 110, 111).
- Both i_lsu_wren and i_lsu_rden asserted: treated as a store only, and the next-cycle o_ld_data is 0.
- Misaligned access:
  - Definition: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Effect: no write occurs, o_ld_data=0, and o_misaligned=1 for exactly the following cycle.
- Illegal funct3 on a store: no write.
- Reset asserted mid-operation: a pending load result is discarded and o_ld_data is forced to 0 immediately (asynchronous).
- DMEM is inferred as word-wide block RAM with per-byte write enables. Index: addr[DMEM_AW-1:2].

Optional Feature:
- Macro: LSU_INPUT_SYNC_EN.
- Defined:
  - i_io_sw and i_io_btn pass through a two-flop synchronizer, reset to 0.
  - A load of SW/BTN returns the value sampled 2 cycles before the request cycle.
- Undefined:
  - SW/BTN are sampled directly in the request cycle.
  - Load latency is unchanged (1 cycle) in both builds.

Test Plan:
- SW 0xDEADBEEF @0x100, next cycle LW @0x100 -> o_ld_data=0xDEADBEEF in the cycle after the LW.
- Byte store/load sign handling:
  - Stimulus: SB 0x80 @0x203, then LB @0x203, then LBU @0x203.
  - Required: o_ld_data 0xFFFFFF80 after the LB and 0x00000080 after the LBU.
  - Required: LW @0x200 returns 0x80 in byte 3, other bytes unchanged.
- SW 0x12345678 @0x10000000 -> o_io_ledr=0x12345678 the next cycle. SH 0x0079 @0x10002002 -> o_io_hex2=0x79 and o_io_hex3=0x00; hex0 and hex1 unchanged.
- SW @0x102 (misaligned) -> memory word at 0x100 unchanged, o_misaligned=1 for one cycle. LHU @0x101 -> o_ld_data=0, o_misaligned=1.
- Switch/button read:
  - Stimulus: drive i_io_sw=0x0000A5A5, then LW @0x10010000.
  - Without the macro: returns 0xA5A5.
  - With the macro: sw must be held ≥2 cycles before the request to return 0xA5A5.
  - Stimulus: LW @0x10011000 with i_io_btn=4'b1010 -> required: 0x0000000A.
- Issue LW, assert i_reset in the next cycle -> o_ld_data=0 and all o_io_* = 0 immediately. DMEM data survives: LW after reset release returns the prior value.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit of the RV32I core.
// Decodes the EX/MEM address into data memory or memory-mapped I/O.
// Performs byte/half/word stores with lane replication and byte enables.
// Returns formatted load data one cycle after the request, aligned with WB.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_lsu_addr, i_st_data     byte address (ALU result), store data (rs2)
//   i_funct3                  access size/sign (B, H, W, BU, HU)
//   i_lsu_wren, i_lsu_rden    store / load request (both set = store only)
//   i_io_sw, i_io_btn         board switches and buttons
//   o_ld_data                 formatted load data, valid the cycle after a load
//   o_misaligned              misalignment flag for the previous request
//   o_io_ledr/ledg/lcd        32-bit output registers
//   o_io_hex0..o_io_hex7      seven-segment output registers
//
// Build option: define LSU_INPUT_SYNC_EN to pass i_io_sw/i_io_btn through a
// two-flop synchronizer before they reach the load path.
module lsu_mem_stage #(
  parameter int unsigned DMEM_AW   = 16,
  parameter string       DMEM_INIT = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_funct3,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7
);

  localparam int unsigned IDX_W      = DMEM_AW - 2;
  localparam int unsigned DMEM_WORDS = 2 ** IDX_W;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [19:0] PG_LEDR   = 20'h10000;
  localparam logic [19:0] PG_LEDG   = 20'h10001;
  localparam logic [19:0] PG_HEX_LO = 20'h10002;
  localparam logic [19:0] PG_HEX_HI = 20'h10003;
  localparam logic [19:0] PG_LCD    = 20'h10004;
  localparam logic [19:0] PG_SW     = 20'h10010;
  localparam logic [19:0] PG_BTN    = 20'h10011;

  // Preloading of data memory is left to the memory/FPGA flow; the
  // parameter is kept so instantiations stay source compatible.
  logic dmem_init_unused;
  assign dmem_init_unused = (DMEM_INIT != "");

  // Switch/button source for loads
  logic [31:0] sw_v;
  logic [3:0]  btn_v;

`ifdef LSU_INPUT_SYNC_EN
  logic [31:0] sw_s1, sw_s2;
  logic [3:0]  btn_s1, btn_s2;

  // Two-flop synchronizer for asynchronous board inputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= i_io_sw;
      sw_s2  <= sw_s1;
      btn_s1 <= i_io_btn;
      btn_s2 <= btn_s1;
    end
  end

  assign sw_v  = sw_s2;
  assign btn_v = btn_s2;
`else
  assign sw_v  = i_io_sw;
  assign btn_v = i_io_btn;
`endif

  // Access decode: size, legality, alignment, lane enables and write data
  logic        is_b, is_h, is_w, legal, misal, access_ok;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        st_en, ld_en;

  always_comb begin
    is_b      = (i_funct3 == F3_B) || (i_funct3 == F3_BU);
    is_h      = (i_funct3 == F3_H) || (i_funct3 == F3_HU);
    is_w      = (i_funct3 == F3_W);
    legal     = is_b || is_h || is_w;
    misal     = (is_h && i_lsu_addr[0]) || (is_w && (i_lsu_addr[1:0] != 2'b00));
    access_ok = legal && !misal;
    be        = 4'b0000;
    wdata     = '0;
    if (is_b) begin
      be    = 4'b0001 << i_lsu_addr[1:0];
      wdata = {4{i_st_data[7:0]}};
    end else if (is_h) begin
      be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{i_st_data[15:0]}};
    end else if (is_w) begin
      be    = 4'b1111;
      wdata = i_st_data;
    end
    st_en = i_lsu_wren && access_ok;
    ld_en = i_lsu_rden && !i_lsu_wren && access_ok;
  end

  // Region decode
  logic [19:0]      page;
  logic             sel_dmem;
  logic [IDX_W-1:0] dmem_idx;

  assign page     = i_lsu_addr[31:12];
  assign sel_dmem = (i_lsu_addr[31:DMEM_AW] == '0);
  assign dmem_idx = i_lsu_addr[DMEM_AW-1:2];

  // Data memory: word-wide RAM with per-byte writes and registered read
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] dmem_rd_q;

  always_ff @(posedge i_clk) begin
    if (st_en && sel_dmem) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) dmem[dmem_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (ld_en) dmem_rd_q <= dmem[dmem_idx];
  end

  // Memory-mapped output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_lcd  <= '0;
      o_io_hex0 <= '0;
      o_io_hex1 <= '0;
      o_io_hex2 <= '0;
      o_io_hex3 <= '0;
      o_io_hex4 <= '0;
      o_io_hex5 <= '0;
      o_io_hex6 <= '0;
      o_io_hex7 <= '0;
    end else if (st_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          if (page == PG_LEDR) o_io_ledr[8*b +: 8] <= wdata[8*b +: 8];
          if (page == PG_LEDG) o_io_ledg[8*b +: 8] <= wdata[8*b +: 8];
          if (page == PG_LCD)  o_io_lcd[8*b +: 8]  <= wdata[8*b +: 8];
        end
      end
      // Bit 7 of each HEX byte lane has no storage
      if (page == PG_HEX_LO) begin
        if (be[0]) o_io_hex0 <= wdata[6:0];
        if (be[1]) o_io_hex1 <= wdata[14:8];
        if (be[2]) o_io_hex2 <= wdata[22:16];
        if (be[3]) o_io_hex3 <= wdata[30:24];
      end
      if (page == PG_HEX_HI) begin
        if (be[0]) o_io_hex4 <= wdata[6:0];
        if (be[1]) o_io_hex5 <= wdata[14:8];
        if (be[2]) o_io_hex6 <= wdata[22:16];
        if (be[3]) o_io_hex7 <= wdata[30:24];
      end
    end
  end

  // I/O read-back mux; unmapped pages read as zero
  logic [31:0] io_rd_c;

  always_comb begin
    io_rd_c = '0;
    case (page)
      PG_LEDR:   io_rd_c = o_io_ledr;
      PG_LEDG:   io_rd_c = o_io_ledg;
      PG_HEX_LO: io_rd_c = {1'b0, o_io_hex3, 1'b0, o_io_hex2, 1'b0, o_io_hex1, 1'b0, o_io_hex0};
      PG_HEX_HI: io_rd_c = {1'b0, o_io_hex7, 1'b0, o_io_hex6, 1'b0, o_io_hex5, 1'b0, o_io_hex4};
      PG_LCD:    io_rd_c = o_io_lcd;
      PG_SW:     io_rd_c = sw_v;
      PG_BTN:    io_rd_c = {28'h0, btn_v};
      default:   io_rd_c = '0;
    endcase
  end

  // Load request pipeline: latch region, offset and format for the WB cycle
  logic        ld_ok_q;
  logic        ld_dmem_q;
  logic [1:0]  ld_off_q;
  logic [2:0]  ld_f3_q;
  logic [31:0] ld_io_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ld_ok_q      <= 1'b0;
      ld_dmem_q    <= 1'b0;
      ld_off_q     <= '0;
      ld_f3_q      <= '0;
      ld_io_q      <= '0;
      o_misaligned <= 1'b0;
    end else begin
      ld_ok_q      <= ld_en;
      o_misaligned <= (i_lsu_wren || i_lsu_rden) && misal;
      if (ld_en) begin
        ld_dmem_q <= sel_dmem;
        ld_off_q  <= i_lsu_addr[1:0];
        ld_f3_q   <= i_funct3;
        ld_io_q   <= io_rd_c;
      end
    end
  end

  // Format the registered word; ld_ok_q gating gives zero after reset/no load
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_word = ld_dmem_q ? dmem_rd_q : ld_io_q;
    ld_half = ld_off_q[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_off_q)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    o_ld_data = '0;
    if (ld_ok_q) begin
      case (ld_f3_q)
        F3_B:    o_ld_data = {{24{ld_byte[7]}}, ld_byte};
        F3_BU:   o_ld_data = {24'h0, ld_byte};
        F3_H:    o_ld_data = {{16{ld_half[15]}}, ld_half};
        F3_HU:   o_ld_data = {16'h0, ld_half};
        F3_W:    o_ld_data = ld_word;
        default: o_ld_data = '0;
      endcase
    end
  end

endmodule
